// File: rtl/div_pkg.sv
// Shared encodings for the sequential divide/remainder unit.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    FAST = 3'd3,
    DONE = 3'd4
  } div_state_e;

  function automatic logic is_signed(input logic [1:0] o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic is_rem(input logic [1:0] o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_div_unit_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN:0]   rem_o,
  output logic            qbit_o
);
  logic [XLEN:0] shifted, diff;

  assign shifted = {rem_i[XLEN-1:0], bit_i};
  assign diff    = shifted - {1'b0, dvsr_i};
  // Partial remainder stays below the divisor, so the top bit of diff is the borrow.
  assign qbit_o  = rem_i[XLEN] | ~diff[XLEN];
  assign rem_o   = qbit_o ? diff : shifted;
endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle RV32M-style divide/remainder: one quotient bit per clock, start/busy/done handshake.
module seq_div_unit
  import div_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q, dvsr_q, result_q;
  logic            isrem_q, negq_q, negr_q, busy_q, done_q;

  logic            sgn_d, a_neg_d, b_neg_d, b_zero_d, ovf_d, special_d;
  logic [XLEN-1:0] abs_a_d, abs_b_d, fast_d, rem_lo;
  logic [XLEN:0]   step_rem;
  logic            step_q;

  assign sgn_d     = is_signed(op);
  assign a_neg_d   = sgn_d & srcA[XLEN-1];
  assign b_neg_d   = sgn_d & srcB[XLEN-1];
  assign b_zero_d  = (srcB == '0);
  assign ovf_d     = sgn_d & (srcA == MOST_NEG) & (srcB == '1);
  assign special_d = b_zero_d | ovf_d;
  assign abs_a_d   = a_neg_d ? -srcA : srcA;
  assign abs_b_d   = b_neg_d ? -srcB : srcB;
  assign fast_d    = b_zero_d ? (is_rem(op) ? srcA : '1) : (is_rem(op) ? '0 : srcA);
  assign rem_lo    = rem_q[XLEN-1:0];

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[XLEN-1]),
    .dvsr_i(dvsr_q),
    .rem_o (step_rem),
    .qbit_o(step_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      isrem_q  <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            busy_q  <= 1'b1;
            isrem_q <= is_rem(op);
            // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
            negq_q  <= (a_neg_d ^ b_neg_d) & ~b_zero_d;
            negr_q  <= a_neg_d;
            dvsr_q  <= abs_b_d;
            rem_q   <= '0;
            cnt_q   <= CW'(XLEN - 1);
            if (special_d && (FAST_SPECIAL != 0)) begin
              quo_q   <= fast_d;
              state_q <= FAST;
            end else begin
              quo_q   <= abs_a_d;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_q};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          result_q <= isrem_q ? (negr_q ? -rem_lo : rem_lo) : (negq_q ? -quo_q : quo_q);
          state_q  <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        FAST: begin
          result_q <= quo_q;
          state_q  <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_seq_div_unit.sv
// Checks a slow-special and a fast-special instance cycle by cycle against an arithmetic reference.
module tb_seq_div_unit;
  import div_pkg::*;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0, srcB = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  logic [31:0] prev0 = '0, prev1 = '0;
  int          vectors = 0, miscompares = 0;

  seq_div_unit #(.XLEN(XLEN), .FAST_SPECIAL(0)) u_slow (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy0), .done(done0), .result(res0));

  seq_div_unit #(.XLEN(XLEN), .FAST_SPECIAL(1)) u_fast (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy1), .done(done1), .result(res1));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 0) return (o == OP_REM || o == OP_REMU) ? a : 32'hFFFF_FFFF;
    if (o == OP_DIVU) return a / b;
    if (o == OP_REMU) return a % b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (o == OP_REM) ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srcA = a; srcB = b; start = 1'b1;
  endtask

  task automatic scramble();
    op = 2'($urandom); srcA = $urandom; srcB = $urandom;
  endtask

  // Caller has driven start; the next rising edge is the accepting edge.
  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int p1, input int p2, input bit chain,
                          input logic [1:0] o2, input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] exp;
    int lat1;
    exp  = model(o, a, b);
    lat1 = special(o, a, b) ? 2 : LAT;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    for (int k = 1; k <= LAT; k++) begin
      chk({name, ".busy_slow"}, 32'(busy0), 32'(k < LAT));
      chk({name, ".done_slow"}, 32'(done0), 32'(k == LAT));
      chk({name, ".res_slow"},  res0, (k >= LAT) ? exp : prev0);
      chk({name, ".busy_fast"}, 32'(busy1), 32'(k < lat1));
      chk({name, ".done_fast"}, 32'(done1), 32'(k == lat1));
      chk({name, ".res_fast"},  res1, (k >= lat1) ? exp : prev1);
      if (k == LAT) break;
      scramble();
      start = (k == p1) || (k == p2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    prev0 = exp;
    prev1 = exp;
    if (chain) start_op(o2, a2, b2);
  endtask

  task automatic gap(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0]  d_op [13] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV,
                              OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REM, OP_DIV};
  logic [31:0] d_a  [13] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFB, 32'hFFFF_FFFB};
  logic [31:0] d_b  [13] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          mode;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy_slow", 32'(busy0), 0); chk("rst.done_slow", 32'(done0), 0);
    chk("rst.res_slow", res0, 0);        chk("rst.busy_fast", 32'(busy1), 0);
    chk("rst.done_fast", 32'(done1), 0); chk("rst.res_fast", res1, 0);
    reset = 1'b1;
    gap(2);

    for (int i = 0; i < 13; i++) begin
      start_op(d_op[i], d_a[i], d_b[i]);
      check_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], 0, 0, 1'b0, 2'b00, 0, 0);
      gap(2);
    end

    // Ignored pulses mid-operation, then a start held in the DONE cycle chains operations.
    start_op(OP_DIVU, 32'd1000, 32'd3);
    check_op("pulse", OP_DIVU, 32'd1000, 32'd3, 5, 20, 1'b1, OP_REMU, 32'd1000, 32'd7);
    check_op("chain1", OP_REMU, 32'd1000, 32'd7, 0, 0, 1'b1, OP_DIV, 32'd9, 32'd0);
    check_op("chain2", OP_DIV, 32'd9, 32'd0, 0, 0, 1'b0, 2'b00, 0, 0);
    gap(2);

    // Reset sampled at the end of cycle 10 aborts the operation.
    start_op(OP_DIVU, 32'd12345, 32'd17);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort.busy_slow", 32'(busy0), 0); chk("abort.done_slow", 32'(done0), 0);
    chk("abort.res_slow", res0, 0);        chk("abort.busy_fast", 32'(busy1), 0);
    chk("abort.done_fast", 32'(done1), 0); chk("abort.res_fast", res1, 0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("abort.nodone_slow", 32'(done0), 0);
      chk("abort.nodone_fast", 32'(done1), 0);
    end
    prev0 = '0;
    prev1 = '0;
    start_op(OP_DIV, 32'hFFFF_FF00, 32'd16);
    check_op("post_rst", OP_DIV, 32'hFFFF_FF00, 32'd16, 0, 0, 1'b0, 2'b00, 0, 0);
    gap(1);

    for (int i = 0; i < 40; i++) begin
      ro   = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 100);
        4: rb = -$urandom_range(1, 15);
        default: ;
      endcase
      start_op(ro, ra, rb);
      check_op($sformatf("rnd%0d", i), ro, ra, rb, 0, 0, 1'b0, 2'b00, 0, 0);
      gap($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
